// File: rtl/x_load_pkg.sv
// Shared types and sizing for the X-load sequencer.
package x_load_pkg;

  localparam int unsigned DATA_W   = 7;
  localparam int unsigned NUM_KEYS = 64;
  localparam int unsigned ADDR_W   = 6;
  localparam int unsigned CNT_W    = 7;

  typedef enum logic [2:0] {
    IDLE,
    START,
    FETCH,
    LOAD,
    WAIT_FIN,
    DONE
  } state_t;

endpackage

// File: rtl/x_load_sequencer_fin_timeout_cnt.sv
// Counts cycles spent waiting for the datapath finish.
// expired is raised while counting once the count reaches TIMEOUT_CYC-1.
module fin_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned   CW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  assign expired = en && (cnt == LAST);

  // Saturates at LAST so the count cannot wrap while still enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/x_load_sequencer.sv
// Streams one batch of keys from key memory to the datapath, then
// waits for the datapath to report finish (with a timeout).
module x_load_sequencer
  import x_load_pkg::*;
#(
  parameter int unsigned NUM_KEYS    = x_load_pkg::NUM_KEYS,
  parameter int unsigned DATA_W      = x_load_pkg::DATA_W,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              abort,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              start_in,
  output logic              valid_input,
  output logic [DATA_W-1:0] X_load,
  input  logic              ready_in,
  input  logic              finish,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  key_cnt
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_KEYS - 1);

  state_t state;
  state_t state_nxt;
  logic   launch;
  logic   accept;
  logic   in_wait;
  logic   fin_expired;
  logic   tmo_hit;

  assign launch  = (state == IDLE) && go && !abort;
  assign accept  = (state == LOAD) && ready_in && !abort;
  assign in_wait = (state == WAIT_FIN);
  assign tmo_hit = in_wait && !abort && !finish && fin_expired;

  fin_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_fin_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (!in_wait),
    .en     (in_wait),
    .expired(fin_expired)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and state-decoded outputs; abort has priority over
  // every other transition out of a busy state.
  always_comb begin
    state_nxt   = state;
    start_in    = 1'b0;
    valid_input = 1'b0;
    done        = 1'b0;
    busy        = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (launch) state_nxt = START;
      end
      START: begin
        start_in  = 1'b1;
        state_nxt = abort ? IDLE : FETCH;
      end
      FETCH: begin
        state_nxt = abort ? IDLE : LOAD;
      end
      LOAD: begin
        valid_input = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else if (ready_in) begin
          state_nxt = (mem_addr == LAST_ADDR) ? WAIT_FIN : FETCH;
        end
      end
      WAIT_FIN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (finish) begin
          state_nxt = DONE;
        end else if (fin_expired) begin
          state_nxt = IDLE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Address, key register, accepted-key count and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr    <= '0;
      X_load      <= '0;
      key_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (launch) begin
        mem_addr    <= '0;
        key_cnt     <= '0;
        timeout_err <= 1'b0;
      end
      if (state == FETCH) begin
        X_load <= mem_rdata;
      end
      if (accept) begin
        key_cnt <= key_cnt + CNT_W'(1);
        if (mem_addr != LAST_ADDR) begin
          mem_addr <= mem_addr + ADDR_W'(1);
        end
      end
      if (tmo_hit) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_x_load_sequencer.sv
// Scoreboard bench: stimulus queues the keys, start pulses and done
// pulses each batch should produce; a negedge monitor consumes them.
module tb_x_load_sequencer;

  localparam int unsigned NK  = 64;
  localparam int unsigned DW  = 7;
  localparam int unsigned TMO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          go;
  logic          abort;
  logic          ready_in;
  logic          finish;
  logic [5:0]    mem_addr;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] X_load;
  logic          start_in;
  logic          valid_input;
  logic          busy;
  logic          done;
  logic          timeout_err;
  logic [6:0]    key_cnt;

  logic [DW-1:0] mem [NK];

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_x[$];
  int            exp_done[$];
  int            exp_starts = 0;
  int            mon_idx    = 0;
  bit            prev_acc   = 1'b0;

  assign mem_rdata = mem[mem_addr];

  always #5 clk = ~clk;

  x_load_sequencer #(
    .NUM_KEYS   (NK),
    .DATA_W     (DW),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .go         (go),
    .abort      (abort),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .start_in   (start_in),
    .valid_input(valid_input),
    .X_load     (X_load),
    .ready_in   (ready_in),
    .finish     (finish),
    .busy       (busy),
    .done       (done),
    .timeout_err(timeout_err),
    .key_cnt    (key_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem(input bit ramp);
    for (int i = 0; i < int'(NK); i++) begin
      mem[i] = ramp ? DW'(i) : DW'($urandom);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_start_in"},    32'(start_in),    0);
    chk({tag, "_valid_input"}, 32'(valid_input), 0);
    chk({tag, "_x_load"},      32'(X_load),      0);
    chk({tag, "_mem_addr"},    32'(mem_addr),    0);
    chk({tag, "_busy"},        32'(busy),        0);
    chk({tag, "_done"},        32'(done),        0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 0);
    chk({tag, "_key_cnt"},     32'(key_cnt),     0);
  endtask

  // Monitor: every valid beat must carry the next queued key at the
  // address/count matching the number of keys already accepted.
  always @(negedge clk) begin
    if (rst) begin
      prev_acc = 1'b0;
    end else begin
      if (prev_acc) chk("beat_gap_valid", 32'(valid_input), 0);
      if (start_in) begin
        chk("start_pending", 32'(exp_starts > 0), 1);
        if (exp_starts > 0) exp_starts--;
        mon_idx = 0;
      end
      if (valid_input) begin
        chk("beat_pending", 32'(exp_x.size() != 0), 1);
        if (exp_x.size() != 0) begin
          chk("beat_x_load",   32'(X_load),   32'(exp_x[0]));
          chk("beat_mem_addr", 32'(mem_addr), mon_idx);
          chk("beat_key_cnt",  32'(key_cnt),  mon_idx);
          if (ready_in && !abort) begin
            void'(exp_x.pop_front());
            mon_idx++;
          end
        end
      end
      prev_acc = valid_input && ready_in && !abort;
      if (done) begin
        chk("done_pending", 32'(exp_done.size() != 0), 1);
        if (exp_done.size() != 0) chk("done_key_cnt", 32'(key_cnt), exp_done.pop_front());
      end
    end
  end

  // One batch. *_key < 0 disables that event; fin_d is the edge count
  // after the last accept at which finish is sampled (0 = never).
  task automatic run_batch(input int ready_pct, input int stall_key, input int abort_key,
                           input int rst_key, input int fin_d, input bit noise);
    int last;
    int accepts;
    int stall_cnt;
    int cyc;
    bit completes;
    bit acc_now;
    accepts   = 0;
    stall_cnt = 0;
    cyc       = 0;
    last      = int'(NK) - 1;
    if (abort_key >= 0) last = abort_key;
    else if (rst_key >= 0) last = rst_key;
    for (int i = 0; i <= last; i++) exp_x.push_back(mem[i]);
    completes = (abort_key < 0) && (rst_key < 0) && (fin_d >= 1) && (fin_d <= int'(TMO));
    exp_starts++;
    if (completes) exp_done.push_back(int'(NK));

    go = 1'b1;
    tick();
    go = 1'b0;
    chk("launch_mem_addr",    32'(mem_addr),    0);
    chk("launch_key_cnt",     32'(key_cnt),     0);
    chk("launch_timeout_err", 32'(timeout_err), 0);
    chk("launch_busy",        32'(busy),        1);

    while (accepts < int'(NK)) begin
      if (cyc >= 4000) begin
        checks++;
        failures++;
        $display("FAIL load_budget accepted=%0d required=%0d", accepts, NK);
        exp_x.delete();
        return;
      end
      ready_in = (int'($urandom_range(99)) < ready_pct);
      abort    = 1'b0;
      finish   = 1'b0;
      go       = 1'b0;
      if (noise) begin
        finish = ($urandom_range(3) == 0);
        go     = ($urandom_range(3) == 0);
      end
      if (valid_input) begin
        if (accepts == stall_key) begin
          ready_in = (stall_cnt >= 3);
          stall_cnt++;
        end
        if (accepts == abort_key) begin
          ready_in = 1'b1;
          abort    = 1'b1;
        end
        if (accepts == rst_key) begin
          ready_in = 1'b0;
          rst      = 1'b1;
          #1;
          chk_all_zero("midrst");
          tick();
          chk_all_zero("midrst_hold");
          rst = 1'b0;
          exp_x.delete();
          tick();
          return;
        end
      end
      acc_now = valid_input && ready_in && !abort;
      tick();
      cyc++;
      if (abort) begin
        abort    = 1'b0;
        ready_in = 1'b0;
        chk("abort_busy",        32'(busy),        0);
        chk("abort_valid_input", 32'(valid_input), 0);
        chk("abort_key_cnt",     32'(key_cnt),     abort_key);
        exp_x.delete();
        tick();
        chk("abort_key_cnt_hold", 32'(key_cnt), abort_key);
        return;
      end
      if (acc_now) begin
        accepts++;
        if (stall_key >= 0 && accepts == stall_key + 1) begin
          chk("stall_key_cnt", 32'(key_cnt), stall_key + 1);
        end
      end
    end
    ready_in = 1'b0;
    finish   = 1'b0;
    go       = 1'b0;

    for (int j = 1; j <= int'(TMO); j++) begin
      finish = (j == fin_d);
      if (j == int'(TMO) && !completes) begin
        chk("pre_timeout_err",  32'(timeout_err), 0);
        chk("pre_timeout_busy", 32'(busy),        1);
      end
      tick();
      finish = 1'b0;
      if (completes && j == fin_d) begin
        tick();
        chk("post_done_busy",    32'(busy),    0);
        chk("post_done_key_cnt", 32'(key_cnt), int'(NK));
        return;
      end
      if (!completes && j == int'(TMO)) begin
        chk("timeout_err_set", 32'(timeout_err), 1);
        chk("timeout_busy",    32'(busy),        0);
        chk("timeout_key_cnt", 32'(key_cnt),     int'(NK));
        return;
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog time_limit_reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    go       = 1'b0;
    abort    = 1'b0;
    ready_in = 1'b0;
    finish   = 1'b0;
    fill_mem(1'b1);
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 0);

    // Ramp keys, ready always high, finish five edges after last accept.
    run_batch(100, -1, -1, -1, 5, 1'b0);
    // Three-cycle stall on key 10.
    run_batch(100, 10, -1, -1, 3, 1'b0);
    // Random keys, random ready, stray finish/go while busy.
    fill_mem(1'b0);
    run_batch(50, -1, -1, -1, int'($urandom_range(1, TMO)), 1'b1);
    // No finish: timeout.
    fill_mem(1'b0);
    run_batch(70, -1, -1, -1, 0, 1'b0);
    repeat (3) tick();
    chk("timeout_sticky", 32'(timeout_err), 1);
    // Abort together with ready on key 20.
    run_batch(100, -1, 20, -1, 5, 1'b0);
    // Reset during key 30, then a full batch from address 0.
    fill_mem(1'b1);
    run_batch(60, -1, -1, 30, 5, 1'b0);
    run_batch(100, -1, -1, -1, TMO, 1'b0);
    // go and abort together in IDLE: stays idle.
    go    = 1'b1;
    abort = 1'b1;
    tick();
    go    = 1'b0;
    abort = 1'b0;
    chk("go_abort_busy", 32'(busy), 0);
    tick();
    chk("go_abort_busy_hold", 32'(busy), 0);
    // Random mix of completions and timeouts.
    for (int b = 0; b < 4; b++) begin
      fill_mem(1'b0);
      run_batch(int'($urandom_range(30, 100)), -1, -1, -1, int'($urandom_range(1, 20)), 1'b1);
      repeat (2) tick();
    end

    repeat (3) tick();
    chk("drain_beats",  32'(exp_x.size()),    0);
    chk("drain_done",   32'(exp_done.size()), 0);
    chk("drain_starts", 32'(exp_starts),      0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/x_load_sequencer.md
X_LOAD_SEQUENCER -- requirements
Module: x_load_sequencer

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 64, giving the keys per batch (range 2..64).
REQ-002 SHALL have parameter DATA_W, default 7, giving the key width.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1024, giving the maximum cycles to wait for finish.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port go, input, 1 bit: request to run one batch, sampled only in IDLE.
REQ-007 SHALL have port abort, input, 1 bit: synchronous cancel of the current batch.
REQ-008 SHALL have port mem_addr, output, 6 bits: key memory read address.
REQ-009 SHALL have port mem_rdata, input, DATA_W bits: key memory data, valid 1 cycle after mem_addr.
REQ-010 SHALL have port start_in, output, 1 bit: batch-start pulse to the datapath.
REQ-011 SHALL have port valid_input, output, 1 bit: X_load holds a valid key.
REQ-012 SHALL have port X_load, output, DATA_W bits: key to the datapath.
REQ-013 SHALL have port ready_in, input, 1 bit: datapath accepts X_load this cycle.
REQ-014 SHALL have port finish, input, 1 bit: datapath has completed the batch.
REQ-015 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-016 SHALL have port done, output, 1 bit: 1-cycle pulse on successful completion.
REQ-017 SHALL have port timeout_err, output, 1 bit: sticky flag, set when finish does not arrive in time.
REQ-018 SHALL have port key_cnt, output, 7 bits: count of keys accepted in the current or last batch.

Function
REQ-019 SHALL implement the states IDLE, START, FETCH, LOAD, WAIT_FIN and DONE.
REQ-020 IDLE, go=1: SHALL clear key_cnt and mem_addr to 0, clear timeout_err, and enter START.
REQ-021 START: SHALL assert start_in for exactly 1 cycle, then enter FETCH.
REQ-022 FETCH: SHALL present mem_addr for 1 cycle, then enter LOAD with X_load set to mem_rdata, registered.
REQ-023 LOAD: SHALL hold valid_input=1 and keep X_load stable until ready_in=1.
REQ-024 On ready_in=1 in LOAD, SHALL increment key_cnt; if mem_addr==NUM_KEYS-1, enter WAIT_FIN, else increment mem_addr and enter FETCH.
REQ-025 valid_input SHALL be 0 outside LOAD; the minimum is 2 cycles per key.
REQ-026 WAIT_FIN: SHALL count cycles from 0; finish=1 SHALL enter DONE.
REQ-027 If the WAIT_FIN count reaches TIMEOUT_CYC-1 without finish, SHALL set timeout_err and enter IDLE with no done pulse.
REQ-028 DONE: SHALL assert done for 1 cycle, then enter IDLE.
REQ-029 finish in any state other than WAIT_FIN SHALL be ignored.
REQ-030 go outside IDLE SHALL be ignored.
REQ-031 abort=1 in any non-IDLE state SHALL enter IDLE on the next edge, with valid_input, start_in and done at 0; key_cnt SHALL hold its value.
REQ-032 If abort and go are both high in IDLE, abort SHALL win and the FSM SHALL stay in IDLE.
REQ-033 If abort and ready_in are both high in LOAD, abort SHALL win and key_cnt SHALL NOT increment.
REQ-034 mem_addr SHALL never exceed NUM_KEYS-1 and SHALL NOT wrap within a batch.
REQ-035 A new go after DONE SHALL restart at address 0.

Reset
REQ-036 rst=1 SHALL asynchronously force state IDLE.
REQ-037 rst=1 SHALL force every output to 0: start_in, valid_input, X_load, mem_addr, busy, done, timeout_err and key_cnt.
REQ-038 rst=1 SHALL clear the timeout counter.
REQ-039 Reset asserted mid-batch SHALL abandon the batch; the first go after reset release SHALL start at address 0.

Structure
REQ-040 Shared package x_load_pkg SHALL hold the state enum, DATA_W, NUM_KEYS, ADDR_W=6 and CNT_W=7.
REQ-041 The finish-timeout counter SHALL be a sub-module fin_timeout_cnt, with ports clk, rst, clr, en and expired.

Verification
REQ-042 Memory loaded with keys 0x00..0x3F, ready_in tied 1, finish 5 cycles after the 64th accept -> start_in pulses once; 64 valid_input beats carry X_load 0x00..0x3F in order; done pulses once; key_cnt=64.
REQ-043 ready_in low for 3 cycles on key 10 -> X_load=0x0A stable and valid_input high through the stall; key_cnt=11 after the accept.
REQ-044 finish never asserted, TIMEOUT_CYC=16 -> timeout_err=1 exactly 16 cycles after WAIT_FIN entry; no done; busy=0.
REQ-045 abort asserted together with ready_in on key 20 -> IDLE next cycle; key_cnt=20; valid_input=0.
REQ-046 rst pulsed during LOAD of key 30, then go -> all outputs 0 during reset; the new batch starts with mem_addr=0 and key_cnt=0.
REQ-047 finish pulsed during LOAD, and go pulsed while busy -> both ignored; batch completes normally with one done.
